// File: rtl/ysyx_22040931_div_ctrl_pkg.sv
// rtl/ysyx_22040931_div_ctrl_pkg.sv - shared types, states and operand helpers for the divide sequencer
package ysyx_22040931_div_ctrl_pkg;

  localparam int XLEN = 64;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] FIX   = 3'd3;
  localparam logic [2:0] HOLD  = 3'd4;

  localparam logic [63:0] MIN_NEG64 = 64'h8000_0000_0000_0000;
  localparam logic [31:0] MIN_NEG32 = 32'h8000_0000;

  typedef struct packed {
    logic w;
    logic is_signed;
    logic rem;
  } div_op_t;

  // W ops see only the low word, widened according to signedness.
  function automatic logic [XLEN-1:0] ext_operand(input logic [XLEN-1:0] x, input logic w,
                                                  input logic sgn);
    if (!w) return x;
    return {{32{sgn & x[31]}}, x[31:0]};
  endfunction

  function automatic logic [XLEN-1:0] w_ext(input logic [XLEN-1:0] x, input logic w);
    return w ? {{32{x[31]}}, x[31:0]} : x;
  endfunction

endpackage

// File: rtl/ysyx_22040931_div_ctrl_if.sv
// rtl/ysyx_22040931_div_ctrl_if.sv - ID/EX request and result handshake of the divide sequencer
interface ysyx_22040931_div_ctrl_if;

  logic                                       in_valid;
  logic                                       in_ready;
  logic                                       in_w;
  logic                                       in_signed;
  logic                                       in_rem;
  logic [ysyx_22040931_div_ctrl_pkg::XLEN-1:0] in_dividend;
  logic [ysyx_22040931_div_ctrl_pkg::XLEN-1:0] in_divisor;
  logic                                       out_valid;
  logic                                       out_ready;
  logic [ysyx_22040931_div_ctrl_pkg::XLEN-1:0] out_result;

  modport master (
    output in_valid, in_w, in_signed, in_rem, in_dividend, in_divisor, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_w, in_signed, in_rem, in_dividend, in_divisor, out_ready,
    output in_ready, out_valid, out_result
  );

endinterface

// File: rtl/ysyx_22040931_div_sign_fix.sv
// rtl/ysyx_22040931_div_sign_fix.sv - operand magnitudes for the core and sign/W restore of its results
module ysyx_22040931_div_sign_fix
  import ysyx_22040931_div_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] in_dividend,
  input  logic [XLEN-1:0] in_divisor,
  input  logic            in_signed,
  output logic [XLEN-1:0] mag_dividend,
  output logic [XLEN-1:0] mag_divisor,
  input  logic            op_w,
  input  logic            op_signed,
  input  logic            dividend_neg,
  input  logic            divisor_neg,
  input  logic [XLEN-1:0] core_quot,
  input  logic [XLEN-1:0] core_rem,
  output logic [XLEN-1:0] fix_quot,
  output logic [XLEN-1:0] fix_rem
);

  logic neg_quot;
  logic neg_rem;

  assign mag_dividend = (in_signed & in_dividend[XLEN-1]) ? -in_dividend : in_dividend;
  assign mag_divisor  = (in_signed & in_divisor[XLEN-1])  ? -in_divisor  : in_divisor;

  // Remainder follows the dividend sign; quotient is negative when signs differ.
  assign neg_quot = op_signed & (dividend_neg ^ divisor_neg);
  assign neg_rem  = op_signed & dividend_neg;

  assign fix_quot = w_ext(neg_quot ? -core_quot : core_quot, op_w);
  assign fix_rem  = w_ext(neg_rem  ? -core_rem  : core_rem,  op_w);

endmodule

// File: rtl/ysyx_22040931_div_ctrl.sv
// rtl/ysyx_22040931_div_ctrl.sv - divide sequencer between ID/EX and the iterative divider core
// Result reuse of the last core computation is built when YSYX_22040931_DIV_REUSE_EN is defined.
module ysyx_22040931_div_ctrl
  import ysyx_22040931_div_ctrl_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  ysyx_22040931_div_ctrl_if.slave  io,
  output logic                     core_start,
  output logic                     core_flush,
  output logic                     core_w,
  output logic [XLEN-1:0]          core_dividend,
  output logic [XLEN-1:0]          core_divisor,
  input  logic                     core_done,
  input  logic [XLEN-1:0]          core_quot,
  input  logic [XLEN-1:0]          core_rem,
  output logic                     busy
);

  logic [2:0]      state;
  div_op_t         op;
  logic [XLEN-1:0] dvd_q, dvs_q, quot_q, rem_q;
  logic [XLEN-1:0] a_dvd, a_dvs, mag_dvd, mag_dvs, fix_quot, fix_rem;
  logic [XLEN-1:0] min_neg, spec_quot, spec_rem, spec_result, hit_result;
  logic            accept, div_zero, overflow, special, hit;

  assign a_dvd = ext_operand(io.in_dividend, io.in_w, io.in_signed);
  assign a_dvs = ext_operand(io.in_divisor,  io.in_w, io.in_signed);

  assign min_neg  = io.in_w ? {{32{1'b1}}, MIN_NEG32} : MIN_NEG64;
  assign div_zero = (a_dvs == '0);
  assign overflow = io.in_signed & (a_dvs == {XLEN{1'b1}}) & (a_dvd == min_neg);
  assign special  = div_zero | overflow;

  assign spec_quot   = div_zero ? {XLEN{1'b1}} : a_dvd;
  assign spec_rem    = div_zero ? a_dvd : '0;
  assign spec_result = w_ext(io.in_rem ? spec_rem : spec_quot, io.in_w);

  assign io.in_ready  = (state == IDLE);
  assign io.out_valid = (state == HOLD);
  assign busy         = (state != IDLE);
  assign core_start   = (state == ISSUE);
  // A redirect in the same cycle as a request wins; the request is simply not taken.
  assign accept       = io.in_valid & io.in_ready & ~flush;

  ysyx_22040931_div_sign_fix u_sign_fix (
    .in_dividend  (a_dvd),
    .in_divisor   (a_dvs),
    .in_signed    (io.in_signed),
    .mag_dividend (mag_dvd),
    .mag_divisor  (mag_dvs),
    .op_w         (op.w),
    .op_signed    (op.is_signed),
    .dividend_neg (dvd_q[XLEN-1]),
    .divisor_neg  (dvs_q[XLEN-1]),
    .core_quot    (quot_q),
    .core_rem     (rem_q),
    .fix_quot     (fix_quot),
    .fix_rem      (fix_rem)
  );

`ifdef YSYX_22040931_DIV_REUSE_EN
  logic            cache_valid, cache_signed, cache_w;
  logic [XLEN-1:0] cache_dvd, cache_dvs, cache_quot, cache_rem;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cache_valid  <= 1'b0;
      cache_signed <= 1'b0;
      cache_w      <= 1'b0;
      cache_dvd    <= '0;
      cache_dvs    <= '0;
      cache_quot   <= '0;
      cache_rem    <= '0;
    end else if (state == FIX) begin
      cache_valid  <= 1'b1;
      cache_signed <= op.is_signed;
      cache_w      <= op.w;
      cache_dvd    <= dvd_q;
      cache_dvs    <= dvs_q;
      cache_quot   <= fix_quot;
      cache_rem    <= fix_rem;
    end
  end

  assign hit = cache_valid & (cache_dvd == a_dvd) & (cache_dvs == a_dvs) &
               (cache_signed == io.in_signed) & (cache_w == io.in_w);
  assign hit_result = io.in_rem ? cache_rem : cache_quot;
`else
  assign hit        = 1'b0;
  assign hit_result = '0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      op            <= '0;
      dvd_q         <= '0;
      dvs_q         <= '0;
      quot_q        <= '0;
      rem_q         <= '0;
      core_flush    <= 1'b0;
      core_w        <= 1'b0;
      core_dividend <= '0;
      core_divisor  <= '0;
      io.out_result <= '0;
    end else begin
      core_flush <= flush & ((state == ISSUE) | (state == WAIT));
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (accept) begin
            op    <= '{w: io.in_w, is_signed: io.in_signed, rem: io.in_rem};
            dvd_q <= a_dvd;
            dvs_q <= a_dvs;
            if (special) begin
              io.out_result <= spec_result;
              state         <= HOLD;
            end else if (hit) begin
              io.out_result <= hit_result;
              state         <= HOLD;
            end else begin
              core_dividend <= mag_dvd;
              core_divisor  <= mag_dvs;
              core_w        <= io.in_w;
              state         <= ISSUE;
            end
          end
          ISSUE: state <= WAIT;
          WAIT: if (core_done) begin
            quot_q <= core_quot;
            rem_q  <= core_rem;
            state  <= FIX;
          end
          FIX: begin
            io.out_result <= op.rem ? fix_rem : fix_quot;
            state         <= HOLD;
          end
          HOLD: if (io.out_ready) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22040931_div_ctrl.sv
// tb/tb_ysyx_22040931_div_ctrl.sv - directed self-checking bench for the divide sequencer
module tb_ysyx_22040931_div_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        core_start, core_flush, core_w, core_done, busy;
  logic [63:0] core_dividend, core_divisor, core_quot, core_rem;
  logic [63:0] seen_dvd, seen_dvs;
  int          checks   = 0;
  int          failures = 0;
  int          starts   = 0;

  always #5 clock = ~clock;

  ysyx_22040931_div_ctrl_if dif ();

  ysyx_22040931_div_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .flush         (flush),
    .io            (dif),
    .core_start    (core_start),
    .core_flush    (core_flush),
    .core_w        (core_w),
    .core_dividend (core_dividend),
    .core_divisor  (core_divisor),
    .core_done     (core_done),
    .core_quot     (core_quot),
    .core_rem      (core_rem),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, act, exp);
    end
  endtask

  // Unsigned core stand-in: done pulses 5 cycles after the start pulse is seen.
  initial begin
    int cnt;
    logic [31:0] a32, b32;
    cnt = 0;
    core_done = 1'b0;
    core_quot = '0;
    core_rem  = '0;
    seen_dvd  = '0;
    seen_dvs  = '0;
    forever begin
      @(negedge clock);
      core_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) core_done = 1'b1;
      end
      if (core_start) begin
        starts++;
        seen_dvd = core_dividend;
        seen_dvs = core_divisor;
        cnt = 5;
        a32 = core_dividend[31:0];
        b32 = core_divisor[31:0];
        if (core_w) begin
          core_quot = (b32 == 0) ? 64'd0 : {32'd0, a32 / b32};
          core_rem  = (b32 == 0) ? 64'd0 : {32'd0, a32 % b32};
        end else begin
          core_quot = (core_divisor == 0) ? 64'd0 : core_dividend / core_divisor;
          core_rem  = (core_divisor == 0) ? 64'd0 : core_dividend % core_divisor;
        end
      end
    end
  end

  task automatic run_op(input logic w, input logic s, input logic r, input logic [63:0] a,
                        input logic [63:0] b, output logic [63:0] res, output int lat);
    bit got;
    got = 1'b0;
    res = '0;
    lat = 0;
    @(negedge clock);
    dif.in_valid    = 1'b1;
    dif.in_w        = w;
    dif.in_signed   = s;
    dif.in_rem      = r;
    dif.in_dividend = a;
    dif.in_divisor  = b;
    dif.out_ready   = 1'b1;
    @(posedge clock);
    #1 dif.in_valid = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clock);
      lat++;
      if (dif.out_valid) begin
        got = 1'b1;
        res = dif.out_result;
      end
    end
    if (!got) check("timeout", 64'd0, 64'd1);
  endtask

  initial begin
    logic [63:0] res;
    int lat, s0, nvalid;
    reset = 1'b0;
    flush = 1'b0;
    dif.in_valid    = 1'b0;
    dif.in_w        = 1'b0;
    dif.in_signed   = 1'b0;
    dif.in_rem      = 1'b0;
    dif.in_dividend = '0;
    dif.in_divisor  = '0;
    dif.out_ready   = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_in_ready", 64'(dif.in_ready), 64'd1);
    check("rst_out_valid", 64'(dif.out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_core_start", 64'(core_start), 64'd0);
    check("rst_core_flush", 64'(core_flush), 64'd0);
    check("rst_out_result", dif.out_result, 64'd0);
    reset = 1'b1;

    run_op(1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, res, lat);
    check("div_m7_2", res, 64'hFFFF_FFFF_FFFF_FFFD);
    check("div_lat", 64'(lat), 64'd8);
    run_op(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, res, lat);
    check("rem_m7_2", res, 64'hFFFF_FFFF_FFFF_FFFF);

    s0 = starts;
    run_op(1'b0, 1'b0, 1'b0, 64'h1234, 64'd0, res, lat);
    check("divu_by0", res, 64'hFFFF_FFFF_FFFF_FFFF);
    check("divu_by0_lat", 64'(lat), 64'd1);
    run_op(1'b0, 1'b0, 1'b1, 64'h1234, 64'd0, res, lat);
    check("remu_by0", res, 64'h1234);
    check("remu_by0_lat", 64'(lat), 64'd1);
    check("by0_no_start", 64'(starts - s0), 64'd0);

    run_op(1'b0, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, res, lat);
    check("div_ovf", res, 64'h8000_0000_0000_0000);
    check("div_ovf_lat", 64'(lat), 64'd1);
    run_op(1'b1, 1'b1, 1'b0, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, res, lat);
    check("divw_ovf", res, 64'hFFFF_FFFF_8000_0000);
    run_op(1'b0, 1'b1, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, res, lat);
    check("rem_ovf", res, 64'd0);
    check("ovf_no_start", 64'(starts - s0), 64'd0);

    run_op(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_0000_0007, 64'd2, res, lat);
    check("remuw", res, 64'd1);
    check("remuw_core_dvd", seen_dvd, 64'd7);
    check("remuw_core_dvs", seen_dvs, 64'd2);
    run_op(1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF, 64'd1, res, lat);
    check("divuw", res, 64'hFFFF_FFFF_FFFF_FFFF);

    // Result held while EX stalls.
    @(negedge clock);
    dif.in_valid    = 1'b1;
    dif.in_w        = 1'b0;
    dif.in_signed   = 1'b0;
    dif.in_rem      = 1'b1;
    dif.in_dividend = 64'h55;
    dif.in_divisor  = 64'd0;
    dif.out_ready   = 1'b0;
    @(posedge clock);
    #1 dif.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("hold_valid", 64'(dif.out_valid), 64'd1);
      check("hold_result", dif.out_result, 64'h55);
      check("hold_in_ready", 64'(dif.in_ready), 64'd0);
    end
    @(negedge clock);
    check("hold_valid_4th", 64'(dif.out_valid), 64'd1);
    dif.out_ready = 1'b1;
    @(negedge clock);
    check("hold_released", 64'(dif.out_valid), 64'd0);
    check("hold_in_ready_back", 64'(dif.in_ready), 64'd1);

    // Flush while waiting on the core; a same-cycle request must be dropped.
    @(negedge clock);
    dif.in_valid    = 1'b1;
    dif.in_w        = 1'b0;
    dif.in_signed   = 1'b1;
    dif.in_rem      = 1'b0;
    dif.in_dividend = 64'd100;
    dif.in_divisor  = 64'd3;
    @(posedge clock);
    #1 dif.in_valid = 1'b0;
    repeat (2) @(negedge clock);
    check("flush_pre_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    dif.in_valid    = 1'b1;
    dif.in_dividend = 64'd9;
    dif.in_divisor  = 64'd0;
    @(posedge clock);
    #1;
    flush = 1'b0;
    dif.in_valid = 1'b0;
    @(negedge clock);
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_core_flush", 64'(core_flush), 64'd1);
    check("flush_out_valid", 64'(dif.out_valid), 64'd0);
    @(negedge clock);
    check("flush_pulse_end", 64'(core_flush), 64'd0);
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (dif.out_valid) nvalid++;
    end
    check("flush_done_ignored", 64'(nvalid), 64'd0);

    run_op(1'b0, 1'b1, 1'b0, 64'd100, 64'd7, res, lat);
    check("div_100_7", res, 64'd14);
    s0 = starts;
    run_op(1'b0, 1'b1, 1'b1, 64'd100, 64'd7, res, lat);
    check("rem_100_7", res, 64'd2);
`ifdef YSYX_22040931_DIV_REUSE_EN
    check("reuse_starts", 64'(starts - s0), 64'd0);
    check("reuse_lat", 64'(lat), 64'd1);
`else
    check("reuse_starts", 64'(starts - s0), 64'd1);
    check("reuse_lat", 64'(lat), 64'd8);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
